// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared types and defaults for the PC fetch sequencer.
// State encoding, next-PC select encoding and the default reset PC.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE,
    HALTED
  } state_t;

  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_JMP
  } sel_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory req/ack bus between the fetch sequencer (master) and memory (slave).
interface pc_fetch_sequencer_if #(
  parameter int AW = 32
);

  logic          req;
  logic [AW-1:0] addr;
  logic          ack;
  logic [31:0]   rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);

endinterface

// File: rtl/pc_fetch_sequencer_next_pc_mux.sv
// Combinational next-PC select (jump > branch > sequential) plus the +1 adder
// that feeds the registered pc_plus_1.
module next_pc_mux
  import pc_seq_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0] pc,
  input  logic          jump,
  input  logic [AW-1:0] jump_target,
  input  logic          branch_taken,
  input  logic [AW-1:0] branch_target,
  output logic [AW-1:0] next_pc,
  output logic [AW-1:0] next_pc_plus_1
);

  sel_t sel;

  always_comb begin
    sel = SEL_SEQ;
    if (jump) begin
      sel = SEL_JMP;
    end else if (branch_taken) begin
      sel = SEL_BR;
    end
  end

  always_comb begin
    next_pc = pc + AW'(1);
    case (sel)
      SEL_JMP: next_pc = jump_target;
      SEL_BR:  next_pc = branch_target;
      default: next_pc = pc + AW'(1);
    endcase
  end

  assign next_pc_plus_1 = next_pc + AW'(1);

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program-counter owner and instruction-fetch sequencer (IDLE/FETCH/ISSUE/HALTED).
// Optional PC_BOUND_CHECK_EN halts with a sticky fault when a new PC exceeds PC_LIMIT.
module pc_fetch_sequencer
  import pc_seq_pkg::*;
#(
  parameter int            AW       = 32,
  parameter logic [AW-1:0] RESET_PC = AW'(DEFAULT_RESET_PC),
  parameter logic [AW-1:0] PC_LIMIT = AW'(32'h0000_03FF)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stall,
  input  logic                 jump,
  input  logic [AW-1:0]        jump_target,
  input  logic                 branch_taken,
  input  logic [AW-1:0]        branch_target,
  input  logic                 halt_req,
  pc_fetch_sequencer_if.master imem,
  output logic [31:0]          instr,
  output logic                 instr_valid,
  output logic [AW-1:0]        pc,
  output logic [AW-1:0]        pc_plus_1,
  output logic                 busy,
  output logic                 fault
);

  state_t        state;
  state_t        state_d;
  logic          pc_load;
  logic          instr_load;
  logic          fault_set;
  logic [AW-1:0] next_pc;
  logic [AW-1:0] next_pc_plus_1;

  next_pc_mux #(.AW(AW)) u_next_pc_mux (
    .pc             (pc),
    .jump           (jump),
    .jump_target    (jump_target),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .next_pc        (next_pc),
    .next_pc_plus_1 (next_pc_plus_1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      pc_plus_1 <= RESET_PC + AW'(1);
      instr     <= '0;
    end else begin
      state <= state_d;
      if (pc_load) begin
        pc        <= next_pc;
        pc_plus_1 <= next_pc_plus_1;
      end
      if (instr_load) begin
        instr <= imem.rdata;
      end
    end
  end

  // Redirect and halt inputs only matter on the accept cycle (ISSUE with no stall).
  always_comb begin
    state_d    = state;
    pc_load    = 1'b0;
    instr_load = 1'b0;
    fault_set  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_d = FETCH;
      end
      FETCH: begin
        if (imem.ack) begin
          instr_load = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (!stall) begin
          if (halt_req) begin
            state_d = HALTED;
          end else begin
            pc_load = 1'b1;
            state_d = FETCH;
`ifdef PC_BOUND_CHECK_EN
            if (next_pc > PC_LIMIT) begin
              state_d   = HALTED;
              fault_set = 1'b1;
            end
`endif
          end
        end
      end
      HALTED: state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  assign imem.req    = (state == FETCH);
  assign imem.addr   = pc;
  assign instr_valid = (state == ISSUE);
  assign busy        = (state == FETCH) || (state == ISSUE);

`ifdef PC_BOUND_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault <= 1'b0;
    end else if (fault_set) begin
      fault <= 1'b1;
    end
  end
`else
  localparam logic [AW-1:0] unused_pc_limit = PC_LIMIT;
  logic unused_fault_set;
  assign unused_fault_set = fault_set;
  assign fault            = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed self-checking bench: main 32-bit instance, 8-bit wrap instance (RESET_PC=FF)
// and a PC_LIMIT=4 instance for the bound-check behaviour.
module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stall, jump, branch_taken, halt_req;
  logic [31:0] jump_target, branch_target;
  logic        ack_auto, ack_force;
  logic        w_start, b_start;

  int nChecks = 0;
  int nErrors = 0;

  always #5 clk = ~clk;

  pc_fetch_sequencer_if #(.AW(32)) m_if ();
  assign m_if.ack   = ack_force | (ack_auto & m_if.req);
  assign m_if.rdata = {16'hC0DE, m_if.addr[15:0]};

  logic [31:0] m_instr, m_pc, m_pc1;
  logic        m_valid, m_busy, m_fault;

  pc_fetch_sequencer #(.AW(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stall         (stall),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt_req      (halt_req),
    .imem          (m_if.master),
    .instr         (m_instr),
    .instr_valid   (m_valid),
    .pc            (m_pc),
    .pc_plus_1     (m_pc1),
    .busy          (m_busy),
    .fault         (m_fault)
  );

  pc_fetch_sequencer_if #(.AW(8)) w_if ();
  assign w_if.ack   = w_if.req;
  assign w_if.rdata = {24'h0, w_if.addr};

  logic [31:0] w_instr;
  logic [7:0]  w_pc, w_pc1;
  logic        w_valid, w_busy, w_fault;

  pc_fetch_sequencer #(.AW(8), .RESET_PC(8'hFF), .PC_LIMIT(8'hFF)) dut_wrap (
    .clk           (clk),
    .rst           (rst),
    .start         (w_start),
    .stall         (1'b0),
    .jump          (1'b0),
    .jump_target   (8'h00),
    .branch_taken  (1'b0),
    .branch_target (8'h00),
    .halt_req      (1'b0),
    .imem          (w_if.master),
    .instr         (w_instr),
    .instr_valid   (w_valid),
    .pc            (w_pc),
    .pc_plus_1     (w_pc1),
    .busy          (w_busy),
    .fault         (w_fault)
  );

  pc_fetch_sequencer_if #(.AW(32)) b_if ();
  assign b_if.ack   = b_if.req;
  assign b_if.rdata = {24'h0, b_if.addr[7:0]};

  logic [31:0] b_instr, b_pc, b_pc1;
  logic        b_valid, b_busy, b_fault;

  pc_fetch_sequencer #(.AW(32), .PC_LIMIT(32'd4)) dut_bound (
    .clk           (clk),
    .rst           (rst),
    .start         (b_start),
    .stall         (1'b0),
    .jump          (1'b0),
    .jump_target   (32'h0),
    .branch_taken  (1'b0),
    .branch_target (32'h0),
    .halt_req      (1'b0),
    .imem          (b_if.master),
    .instr         (b_instr),
    .instr_valid   (b_valid),
    .pc            (b_pc),
    .pc_plus_1     (b_pc1),
    .busy          (b_busy),
    .fault         (b_fault)
  );

  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    halt_req = 1'b0; jump_target = '0; branch_target = '0;
    ack_auto = 1'b1; ack_force = 1'b0; w_start = 1'b0; b_start = 1'b0;
    applyStimulus(2);

    checkOutput("rst_pc", m_pc, 0);
    checkOutput("rst_pc1", m_pc1, 1);
    checkOutput("rst_instr", m_instr, 0);
    checkOutput("rst_valid", m_valid, 0);
    checkOutput("rst_req", m_if.req, 0);
    checkOutput("rst_busy", m_busy, 0);
    checkOutput("rst_fault", m_fault, 0);
    checkOutput("rst_wrap_pc", w_pc, 8'hFF);
    checkOutput("rst_wrap_pc1", w_pc1, 8'h00);

    rst = 1'b0;
    applyStimulus(1);
    checkOutput("idle_req", m_if.req, 0);
    start = 1'b1;
    applyStimulus(1);
    start = 1'b0;

    // Zero-wait sequential fetch: FETCH/ISSUE alternate for pc 0..3.
    for (int i = 0; i < 4; i++) begin
      checkOutput("seq_req", m_if.req, 1);
      checkOutput("seq_addr", m_if.addr, 64'(i));
      applyStimulus(1);
      checkOutput("seq_valid", m_valid, 1);
      checkOutput("seq_pc", m_pc, 64'(i));
      checkOutput("seq_pc1", m_pc1, 64'(i + 1));
      checkOutput("seq_instr", m_instr, 64'(32'hC0DE_0000 + i));
      checkOutput("seq_busy", m_busy, 1);
      applyStimulus(1);
      checkOutput("seq_valid_low", m_valid, 0);
    end

    applyStimulus(1);
    ack_auto = 1'b0;
    applyStimulus(1);
    for (int k = 0; k < 3; k++) begin
      checkOutput("wait_req", m_if.req, 1);
      checkOutput("wait_addr", m_if.addr, 5);
      checkOutput("wait_valid", m_valid, 0);
      applyStimulus(1);
    end
    ack_force = 1'b1;
    applyStimulus(1);
    ack_force = 1'b0;
    stall = 1'b1; jump = 1'b1; jump_target = 32'd99; halt_req = 1'b1;
    checkOutput("ack_valid", m_valid, 1);
    checkOutput("ack_instr", m_instr, 32'hC0DE_0005);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1);
      checkOutput("stall_valid", m_valid, 1);
      checkOutput("stall_pc", m_pc, 5);
      checkOutput("stall_instr", m_instr, 32'hC0DE_0005);
      checkOutput("stall_req", m_if.req, 0);
    end
    stall = 1'b0; jump = 1'b0; halt_req = 1'b0; ack_auto = 1'b1;
    applyStimulus(1);
    checkOutput("release_addr", m_if.addr, 6);
    checkOutput("release_req", m_if.req, 1);

    applyStimulus(5);
    checkOutput("redir_at8_pc", m_pc, 8);
    checkOutput("redir_at8_valid", m_valid, 1);
    jump = 1'b1; jump_target = 32'd40; branch_taken = 1'b1; branch_target = 32'd20;
    applyStimulus(1);
    checkOutput("jump_wins_addr", m_if.addr, 40);
    checkOutput("jump_pc1", m_pc1, 41);
    jump = 1'b0; branch_taken = 1'b0;
    applyStimulus(1);
    checkOutput("at40_pc", m_pc, 40);
    branch_taken = 1'b1; branch_target = 32'd20;
    applyStimulus(1);
    checkOutput("branch_addr", m_if.addr, 20);
    branch_taken = 1'b0;

    // Halt on accept at pc=3; start afterwards must be ignored.
    rst = 1'b1;
    applyStimulus(1);
    rst = 1'b0;
    start = 1'b1;
    applyStimulus(1);
    start = 1'b0;
    applyStimulus(7);
    checkOutput("halt_at_pc", m_pc, 3);
    checkOutput("halt_at_valid", m_valid, 1);
    halt_req = 1'b1;
    applyStimulus(1);
    halt_req = 1'b0;
    checkOutput("halted_req", m_if.req, 0);
    checkOutput("halted_valid", m_valid, 0);
    checkOutput("halted_busy", m_busy, 0);
    checkOutput("halted_pc", m_pc, 3);
    start = 1'b1;
    applyStimulus(3);
    start = 1'b0;
    checkOutput("halted_start_req", m_if.req, 0);
    checkOutput("halted_start_pc", m_pc, 3);

    // Asynchronous reset in the middle of a FETCH, then a late ack.
    rst = 1'b1;
    applyStimulus(1);
    rst = 1'b0; ack_auto = 1'b0;
    start = 1'b1;
    applyStimulus(1);
    start = 1'b0;
    checkOutput("midfetch_req", m_if.req, 1);
    applyStimulus(1);
    checkOutput("midfetch_busy", m_busy, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_req", m_if.req, 0);
    checkOutput("async_rst_busy", m_busy, 0);
    checkOutput("async_rst_valid", m_valid, 0);
    ack_force = 1'b1;
    applyStimulus(1);
    rst = 1'b0;
    applyStimulus(2);
    checkOutput("late_ack_req", m_if.req, 0);
    checkOutput("late_ack_valid", m_valid, 0);
    checkOutput("late_ack_instr", m_instr, 0);
    checkOutput("late_ack_busy", m_busy, 0);
    ack_force = 1'b0;

    // 8-bit PC wraps from FF to 0.
    w_start = 1'b1;
    applyStimulus(1);
    w_start = 1'b0;
    checkOutput("wrap_req", w_if.req, 1);
    checkOutput("wrap_addr", w_if.addr, 8'hFF);
    applyStimulus(1);
    checkOutput("wrap_issue_pc", w_pc, 8'hFF);
    checkOutput("wrap_issue_valid", w_valid, 1);
    checkOutput("wrap_issue_instr", w_instr, 32'h0000_00FF);
    applyStimulus(1);
    checkOutput("wrap_pc", w_pc, 8'h00);
    checkOutput("wrap_pc1", w_pc1, 8'h01);
    checkOutput("wrap_fault", w_fault, 0);
    checkOutput("wrap_busy", w_busy, 1);

    // PC_LIMIT=4: accepting pc=4 produces pc=5.
    b_start = 1'b1;
    applyStimulus(1);
    b_start = 1'b0;
    applyStimulus(10);
    checkOutput("bound_pc", b_pc, 5);
    checkOutput("bound_pc1", b_pc1, 6);
    checkOutput("bound_valid", b_valid, 0);
    checkOutput("bound_instr", b_instr, 32'h0000_0004);
`ifdef PC_BOUND_CHECK_EN
    checkOutput("bound_fault", b_fault, 1);
    checkOutput("bound_req", b_if.req, 0);
    checkOutput("bound_busy", b_busy, 0);
    applyStimulus(2);
    checkOutput("bound_fault_sticky", b_fault, 1);
    checkOutput("bound_pc_held", b_pc, 5);
    checkOutput("bound_req_held", b_if.req, 0);
`else
    checkOutput("bound_fault", b_fault, 0);
    checkOutput("bound_req", b_if.req, 1);
    checkOutput("bound_addr", b_if.addr, 5);
    checkOutput("bound_busy", b_busy, 1);
`endif

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Controller that owns the program counter and sequences instruction fetch from instruction memory.
- Selects the next PC (sequential +1, branch target, jump target) and runs a req/ack handshake with instruction memory.
- Presents each fetched instruction, with its PC and PC+1, to decode, holding it until decode accepts it.
- Sits between the register/branch logic and the instruction memory. It supersedes ad-hoc PC tracking in the datapath.

Parameters:
- AW, 32, PC/address width in bits; PC is word-addressed and increments by 1.
- RESET_PC, 0, PC value loaded on reset.
- PC_LIMIT, 32'h0000_03FF, highest legal PC; used only when PC_BOUND_CHECK_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins fetching from the current PC while in IDLE.
- stall  in  1  decode not ready; holds the presented instruction.
- jump  in  1  jump redirect, sampled on accept.
- jump_target  in  AW  jump destination.
- branch_taken  in  1  branch redirect, sampled on accept.
- branch_target  in  AW  branch destination.
- halt_req  in  1  stop fetching after the current instruction is accepted.
- imem_req  out  1  fetch request.
- imem_addr  out  AW  fetch address (equals pc).
- imem_ack  in  1  memory has returned imem_rdata this cycle.
- imem_rdata  in  32  instruction word.
- instr  out  32  latched instruction.
- instr_valid  out  1  instr, pc and pc_plus_1 are valid for decode.
- pc  out  AW  PC of the current/presented instruction.
- pc_plus_1  out  AW  pc+1, modulo 2^AW.
- busy  out  1  high in FETCH or ISSUE.
- fault  out  1  PC out of bounds (feature only; otherwise tied 0).

Behaviour:
- Reset (async, any state, including mid-handshake):
  - state=IDLE, pc=RESET_PC, instr=0.
  - instr_valid=0, imem_req=0, busy=0, fault=0.
  - An imem_ack that arrives after reset is ignored.
- States:
  - IDLE: imem_req=0. start=1 moves to FETCH next cycle.
  - FETCH: imem_req=1, imem_addr=pc, both held stable until imem_ack. When imem_ack=1 (an ack in the first request cycle is legal), instr<=imem_rdata and the next state is ISSUE. imem_ack outside FETCH is ignored.
  - ISSUE: instr_valid=1, imem_req=0. Accept occurs when stall=0.
    - On accept, priority is halt_req > jump > branch_taken > sequential.
    - halt_req: go to HALTED, pc unchanged.
    - jump: pc<=jump_target, go to FETCH.
    - branch_taken: pc<=branch_target, go to FETCH.
    - otherwise: pc<=pc+1 (wraps to 0 at 2^AW-1), go to FETCH.
    - While stall=1, instr, pc and instr_valid hold, and redirect/halt inputs are ignored.
  - HALTED: all handshake outputs 0, pc held. Exits only via rst.
- Output relations:
  - instr_valid is registered and high for exactly the cycles spent in ISSUE.
  - pc_plus_1 is always pc+1 (AW bits, carry discarded), registered together with pc.
- Latency and throughput:
  - start → imem_req is 1 cycle.
  - ack → instr_valid is 1 cycle.
  - Peak throughput is 1 instruction per 2 cycles (FETCH, ISSUE) with zero-wait memory.
- start is ignored outside IDLE. Simultaneous jump and branch_taken: jump wins.

Optional Feature:
- Macro: PC_BOUND_CHECK_EN.
- Defined: on every pc update, if the new PC > PC_LIMIT, go to HALTED instead of FETCH. fault is set 1 and is sticky until rst. pc is loaded with the offending value so software can inspect it.
- Undefined: no check, fault is constant 0, and PC_LIMIT is unused.

Decomposition:
- Shared package (pc_seq_pkg):
  - state enum {IDLE, FETCH, ISSUE, HALTED}.
  - next-PC select encoding {SEL_SEQ, SEL_BR, SEL_JMP}.
  - RESET_PC default constant.
- Sub-module: next_pc_mux. It is combinational: priority select plus +1 adder, producing next_pc and next_pc_plus_1. The FSM and registers stay in the top.

Test Plan:
- Reset/sequential: rst, start, memory acks every request in 0 wait → pc sequence 0,1,2,3; instr_valid pulses every 2nd cycle; pc_plus_1=pc+1.
- Wait states and stall: ack delayed 3 cycles with imem_addr held at 5; then stall=1 for 4 cycles → instr, pc=5 and instr_valid held; on release, next fetch addr=6.
- Redirect priority: at pc=8 assert jump (target 40) and branch_taken (target 20) together → next imem_addr=40; branch alone at pc=40 (target 20) → 20.
- Wrap: AW=8, RESET_PC=8'hFF → after accept, pc=0 and pc_plus_1=1.
- Halt and async reset mid-fetch: halt_req at pc=3 → HALTED, no further imem_req. rst asserted during FETCH with a late ack → outputs go to reset values immediately and the ack is ignored.
- PC_BOUND_CHECK_EN: PC_LIMIT=4, sequential run → accepting pc=4 gives pc=5, fault=1, HALTED. Macro undefined → fetch continues at 5 with fault=0.
